alu_issue_ctrl_24bit: RTL

Issuing end of the 24-bit ALU interface. Accepts decoded arithmetic requests over a valid/ready handshake and drives the ALU's operand and control inputs (A, B, ALUOp, AInvert, BNegate). Captures Result, Zero, Overflow and CarryOut, and returns result plus flags over a response handshake. Also sequences a multi-cycle 24x24 unsigned multiply (low 24 bits) by iterating the ALU add path. Sits between the decode stage and the ALU in the CPU datapath.

---
 rtl/alu_issue_ctrl_24bit_pkg.sv | 33 +++
 rtl/alu_issue_ctrl_24bit_mul_seq.sv | 53 +++++
 rtl/alu_issue_ctrl_24bit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_24bit_pkg.sv
// Shared constants for the 24-bit ALU issue controller.
// Holds request opcodes, ALUOp encodings, flag bit positions and the FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_NOR = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam int MUL_STEPS = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_24bit_mul_seq.sv
// Shift-and-add multiply sequencer; the add itself is done by the shared external ALU.
// Produces the low WIDTH bits of the product after MUL_STEPS iterations.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_sum,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0] o_acc_next,
  output logic             o_done
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [4:0]       r_count;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? i_sum : r_acc;
  assign o_acc      = r_acc;
  assign o_mcand    = r_mcand;
  assign o_acc_next = w_acc_next;
  // done marks the final iteration so the controller can capture w_acc_next that same edge
  assign o_done     = i_step && (r_count == 5'(MUL_STEPS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 5'd1;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl_24bit.sv
// Issue controller between decode and the 24-bit ALU: drives ALU controls,
// captures result/flags and returns them over a response handshake; sequences MUL.
module alu_issue_ctrl_24bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int OPW   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [OPW-1:0]   i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_ainvert,
  output logic             o_alu_bnegate,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  input  logic             i_alu_overflow,
  input  logic             i_alu_carryout,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic [3:0]       o_rsp_flags,
  output logic             o_rsp_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_rsp_fire;
  logic             w_op_legal;
  logic             w_logic_op;
  logic             w_mul_start;
  logic             w_mul_step;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_mcand;
  logic [WIDTH-1:0] w_mul_acc_next;
  logic [WIDTH-1:0] w_exec_result;
  logic [3:0]       w_exec_flags;
  logic [3:0]       w_mul_flags;

  assign w_accept    = (r_state == ST_IDLE) && i_req_valid && r_req_ready;
  assign w_rsp_fire  = r_rsp_valid && i_rsp_ready;
  assign w_op_legal  = (i_req_op <= OP_CMP);
  assign w_mul_start = w_accept && (i_req_op == OP_MUL);
  assign w_mul_step  = (r_state == ST_MUL);
  assign w_logic_op  = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_NOR);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_mul_start),
    .i_step     (w_mul_step),
    .i_a        (i_req_a),
    .i_b        (i_req_b),
    .i_sum      (i_alu_result),
    .o_acc      (w_mul_acc),
    .o_mcand    (w_mul_mcand),
    .o_acc_next (w_mul_acc_next),
    .o_done     (w_mul_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (!w_op_legal)              w_state_next = ST_RESP;
        else if (i_req_op == OP_MUL)  w_state_next = ST_MUL;
        else                          w_state_next = ST_EXEC;
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_MUL:  if (w_mul_done) w_state_next = ST_RESP;
      ST_RESP: if (w_rsp_fire) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The ALU sees the registered operands in EXEC and the multiply datapath in MUL; idle otherwise
  always_comb begin
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_op      = ALU_AND;
    o_alu_ainvert = 1'b0;
    o_alu_bnegate = 1'b0;
    if (r_state == ST_EXEC) begin
      o_alu_a = r_a;
      o_alu_b = r_b;
      case (r_op)
        OP_AND: o_alu_op = ALU_AND;
        OP_OR:  o_alu_op = ALU_OR;
        OP_ADD: o_alu_op = ALU_ADD;
        OP_SUB, OP_CMP: begin
          o_alu_op      = ALU_ADD;
          o_alu_bnegate = 1'b1;
        end
        OP_SLT: begin
          o_alu_op      = ALU_SLT;
          o_alu_bnegate = 1'b1;
        end
        OP_NOR: begin
          o_alu_op      = ALU_AND;
          o_alu_ainvert = 1'b1;
          o_alu_bnegate = 1'b1;
        end
        default: o_alu_op = ALU_AND;
      endcase
    end else if (r_state == ST_MUL) begin
      o_alu_a  = w_mul_acc;
      o_alu_b  = w_mul_mcand;
      o_alu_op = ALU_ADD;
    end
  end

  always_comb begin
    w_exec_result          = (r_op == OP_CMP) ? '0 : i_alu_result;
    w_exec_flags           = '0;
    w_exec_flags[FLAG_Z]   = i_alu_zero;
    w_exec_flags[FLAG_N]   = i_alu_result[WIDTH-1];
    w_exec_flags[FLAG_V]   = w_logic_op ? 1'b0 : i_alu_overflow;
    w_exec_flags[FLAG_C]   = w_logic_op ? 1'b0 : i_alu_carryout;
    w_mul_flags            = '0;
    w_mul_flags[FLAG_Z]    = (w_mul_acc_next == '0);
    w_mul_flags[FLAG_N]    = w_mul_acc_next[WIDTH-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_op        <= i_req_op;
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            if (!w_op_legal) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_result <= w_exec_result;
          r_rsp_flags  <= w_exec_flags;
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= w_mul_acc_next;
            r_rsp_flags  <= w_mul_flags;
          end
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_req_ready <= 1'b0;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_flags  = r_rsp_flags;
  assign o_rsp_err    = r_rsp_err;

endmodule
